// File: rtl/sram_player_pkg.sv
// Shared constants and state encoding for the SRAM playback engine.
package sram_player_pkg;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READY = 2'd2
    } state_t;
endpackage

// File: rtl/sram_player_edge_sync.sv
// Two-flop synchroniser for a codec pin, with single-cycle rise/fall pulses.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[1:0], din};
    end

    // sync[2] is the previous synchronised level, so pulses act on the 3rd clk
    assign rise = sync[1] & ~sync[2];
    assign fall = ~sync[1] & sync[2];
endmodule

// File: rtl/sram_player.sv
// Plays 16-bit mono samples from the external SRAM to the codec DAC,
// left-justified, MSB first, same sample on both channels.
//
//   state    | meaning
//   ST_IDLE  | stopped, strobes inactive, waiting for play
//   ST_FETCH | read strobes low, counting READ_WAIT before capturing data
//   ST_READY | next sample buffered, waiting for an LRCK edge
module sram_player
    import sram_player_pkg::*;
#(
    parameter int READ_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              stop,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    input  logic              aud_bclk,
    input  logic              aud_daclrck,
    output logic              aud_dacdat,
    output logic              busy,
    output logic [ADDR_W-1:0] play_addr
);
    localparam logic [7:0] WAIT_LOAD = 8'(READ_WAIT - 1);
    localparam logic [4:0] BITS      = 5'(DATA_W);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt, play_addr_nxt;
    logic [DATA_W-1:0] buffer, buffer_nxt, cur, cur_nxt, shift, shift_nxt;
    logic              rd_n, rd_n_nxt, busy_nxt, last, last_nxt, tail, tail_nxt;
    logic [7:0]        wait_cnt, wait_cnt_nxt;
    logic [4:0]        bit_cnt, bit_cnt_nxt;
    logic              bclk_rise_unused, bclk_fall, lr_rise, lr_fall;
    logic              at_end, fin_done;

    edge_sync u_bclk_sync (
        .clk(clk), .rst_n(rst_n), .din(aud_bclk), .rise(bclk_rise_unused), .fall(bclk_fall)
    );
    edge_sync u_lrck_sync (
        .clk(clk), .rst_n(rst_n), .din(aud_daclrck), .rise(lr_rise), .fall(lr_fall)
    );

    assign at_end = (addr == end_addr);
    // last bit of the final right channel has just been shifted out
    assign fin_done = (state == ST_READY) && tail && bclk_fall && !lr_fall && (bit_cnt == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (play) state_nxt = ST_FETCH;
                ST_FETCH: if (wait_cnt == '0) state_nxt = ST_READY;
                ST_READY: begin
                    if (fin_done)                         state_nxt = ST_IDLE;
                    else if (lr_rise && !last && !at_end) state_nxt = ST_FETCH;
                end
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_nxt      = addr;
        play_addr_nxt = play_addr;
        buffer_nxt    = buffer;
        cur_nxt       = cur;
        shift_nxt     = shift;
        rd_n_nxt      = rd_n;
        busy_nxt      = busy;
        last_nxt      = last;
        tail_nxt      = tail;
        wait_cnt_nxt  = wait_cnt;
        bit_cnt_nxt   = bit_cnt;
        if (stop) begin
            rd_n_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            shift_nxt = '0;
            last_nxt  = 1'b0;
            tail_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (play) begin
                    addr_nxt     = '0;
                    busy_nxt     = 1'b1;
                    rd_n_nxt     = 1'b0;
                    wait_cnt_nxt = WAIT_LOAD;
                    last_nxt     = 1'b0;
                    tail_nxt     = 1'b0;
                end
                ST_FETCH: begin
                    if (wait_cnt == '0) begin
                        buffer_nxt = sram_dq_i;
                        rd_n_nxt   = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt - 1'b1;
                    end
                end
                ST_READY: if (lr_rise && !last) begin
                    if (at_end) begin
                        last_nxt = 1'b1;
                    end else begin
                        addr_nxt     = addr + 1'b1;
                        rd_n_nxt     = 1'b0;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
                default: ;
            endcase

            // An LRCK rise during FETCH is an underflow: the current sample is resent.
            if (state != ST_IDLE) begin
                if (fin_done) begin
                    busy_nxt  = 1'b0;
                    shift_nxt = '0;
                    last_nxt  = 1'b0;
                    tail_nxt  = 1'b0;
                end else if (lr_rise) begin
                    if (state == ST_READY && !last) begin
                        cur_nxt       = buffer;
                        shift_nxt     = buffer;
                        play_addr_nxt = addr;
                    end else begin
                        shift_nxt = cur;
                    end
                end else if (lr_fall) begin
                    shift_nxt   = cur;
                    bit_cnt_nxt = BITS;
                    tail_nxt    = last;
                end else if (bclk_fall) begin
                    shift_nxt = {shift[DATA_W-2:0], 1'b0};
                    if (bit_cnt != '0) bit_cnt_nxt = bit_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            play_addr <= '0;
            buffer    <= '0;
            cur       <= '0;
            shift     <= '0;
            rd_n      <= 1'b1;
            busy      <= 1'b0;
            last      <= 1'b0;
            tail      <= 1'b0;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
        end else begin
            addr      <= addr_nxt;
            play_addr <= play_addr_nxt;
            buffer    <= buffer_nxt;
            cur       <= cur_nxt;
            shift     <= shift_nxt;
            rd_n      <= rd_n_nxt;
            busy      <= busy_nxt;
            last      <= last_nxt;
            tail      <= tail_nxt;
            wait_cnt  <= wait_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    assign sram_addr  = addr;
    assign sram_ce_n  = rd_n;
    assign sram_oe_n  = rd_n;
    assign sram_ub_n  = rd_n;
    assign sram_lb_n  = rd_n;
    assign sram_we_n  = 1'b1;
    assign aud_dacdat = shift[DATA_W-1];
endmodule

// File: doc/sram_player.md
# sram_player

Playback engine for the audio recorder: reads 16-bit mono samples sequentially from the external 256K×16 SRAM and serialises each one to the audio codec DAC, left-justified, MSB first, with the same sample on both channels. It is the read-side counterpart of the record path, sharing the same SRAM pins under top-level arbitration. Playback starts on a `play` pulse and stops at the recorder's last written address or on `stop`.

## Interface
- `ADDR_W`, 18: SRAM word-address width.
- `DATA_W`, 16: sample width.
- `READ_WAIT`, 2: cycles `sram_oe_n` is held low before `sram_dq_i` is sampled (≥1).
- `clk`, in, 1: system clock, 50 MHz; must be ≥4× `aud_bclk`.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `play`, in, 1: start pulse, one `clk` wide.
- `stop`, in, 1: abort pulse, one `clk` wide.
- `end_addr`, in, ADDR_W: last valid sample address, inclusive; held stable while `busy`.
- `sram_addr`, out, ADDR_W: SRAM address.
- `sram_dq_i`, in, DATA_W: SRAM read data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`, out, 1 each: SRAM strobes, active-low.
- `aud_bclk`, in, 1: codec bit clock; asynchronous to `clk`.
- `aud_daclrck`, in, 1: codec DAC frame clock; high = left channel; asynchronous to `clk`.
- `aud_dacdat`, out, 1: serial DAC data.
- `busy`, out, 1: playback active.
- `play_addr`, out, ADDR_W: address of the sample currently being shifted out.

## Operation
- States: IDLE, FETCH, READY.
- IDLE: strobes inactive, `busy`=0. On `play` with `stop`=0: address := 0, `busy`:=1, go to FETCH.
- FETCH: `sram_ce_n`=`sram_oe_n`=`sram_ub_n`=`sram_lb_n`=0. After READ_WAIT cycles, latch `sram_dq_i` into the sample buffer, deassert strobes, go to READY.
- READY: wait for an LRCK edge. `aud_bclk` and `aud_daclrck` are each passed through 2-flop synchronisers with edge detection.
- LRCK rising edge (left channel): load the shift register from the buffer and set `play_addr` to that sample's address.
  - If address == `end_addr`: final sample; return to IDLE after the right channel completes.
  - Otherwise: address+1, go to FETCH, which prefetches the next sample.
- LRCK falling edge (right channel): reload the shift register with the same sample.
- Each synchronised BCLK falling edge shifts the register left by 1. `aud_dacdat` = MSB; after 16 bits it outputs 0 until the next reload.
- `sram_we_n` is tied to 1 at all times.
- `stop` in any state: next cycle go to IDLE, strobes inactive, `aud_dacdat`=0, `busy`=0. `stop` beats a simultaneous `play`.
- `play` while `busy`: ignored.
- Underflow: if an LRCK rising edge arrives while in FETCH, resend the previous sample and advance the address only once.
- Address does not wrap; `end_addr`=0 plays exactly one sample.

## Timing
- All outputs are registered. Reset values: `sram_addr`=0, all `*_n`=1, `aud_dacdat`=0, `busy`=0, `play_addr`=0, state IDLE.
- Reset asserted mid-playback returns all outputs to their reset values immediately (asynchronous).
- `play` in cycle 0: `busy`=1, `sram_ce_n`=0, `sram_oe_n`=0 and `sram_addr`=0 in cycle 1. Data is captured at the end of cycle READ_WAIT; strobes are high in cycle READ_WAIT+1.
- Synchroniser latency is 3 `clk` from a codec pin edge to the resulting action (load or shift).
- After the final sample's right channel finishes: `busy` falls 1 cycle after the last LRCK falling edge plus 16 BCLKs.

## Structure
- Shared package: `ADDR_W` and `DATA_W` constants, and the player state enum (IDLE/FETCH/READY).
- Sub-module `edge_sync`: 2-flop synchroniser plus rise/fall pulse outputs. Instantiated twice, once for `aud_bclk` and once for `aud_daclrck`.

## Test plan
- Reset: assert `rst_n`=0 mid-FETCH -> all strobes 1, `aud_dacdat`=0, `busy`=0 in the same cycle.
- Basic playback: SRAM model preloaded with 0xA5C3, 0x1234 at addresses 0 and 1; `end_addr`=1; `play` -> DAC serial stream decodes to L=R=0xA5C3, then L=R=0x1234; `busy` falls afterwards; no read at address 2.
- Read strobe timing: READ_WAIT=3 -> `sram_oe_n` low for exactly 3 cycles per fetch; `sram_we_n` never 0.
- Stop: `stop` mid-word at address 5 -> next cycle IDLE, `aud_dacdat`=0, `busy`=0. Simultaneous `play`+`stop` from IDLE -> stays IDLE.
- Underflow: force an LRCK rising edge while in FETCH -> previous sample is repeated and `play_addr` advances by exactly 1 overall.
- Single-sample playback: `end_addr`=0 -> exactly one sample is played, then `busy`=0.
